// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer.
// Operands of 16*WORDS bits are processed one 16-bit slice per clock through a
// single ripple-carry adder (Add_rca). The carry between slices is held in a
// register. Results are returned with a start/busy/done handshake.

// 16-bit ripple-carry adder used as the per-slice arithmetic unit.
module Add_rca (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [16:0] carry;

  assign carry[0] = c_in;

  // One full adder per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign c_out = carry[16];

endmodule

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; sum/c_out/ovf hold the last result
// RUN   | one slice per clock, idx selects the slice, carry chained in reg
module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                c_in,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                c_out,
  output logic                ovf
);

  localparam int W     = 16 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_eff_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             done_q;

  logic             accept;
  logic             step;
  logic             last;

  logic [15:0]      a_slice;
  logic [15:0]      b_slice;
  logic [15:0]      add_sum;
  logic             add_co;

  // Current slice of the captured operands feeds the shared adder.
  assign a_slice = a_q[16*idx_q +: 16];
  assign b_slice = b_eff_q[16*idx_q +: 16];
  assign last    = (idx_q == IDX_LAST);

  Add_rca u_add_rca (
    .a     (a_slice),
    .b     (b_slice),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_co)
  );

  // State register; reset drops any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start is only looked at in IDLE, so starts during RUN are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    busy   = 1'b0;
    case (state_q)
      IDLE: accept = start;
      RUN: begin
        step = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture on accept, one slice written per RUN cycle.
  // Subtract is folded into the capture (invert b and the incoming borrow),
  // so RUN itself never looks at op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_eff_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= a;
        b_eff_q <= op ? ~b : b;
        carry_q <= op ? ~c_in : c_in;
        sum_q   <= '0;
        idx_q   <= '0;
      end else if (step) begin
        sum_q[16*idx_q +: 16] <= add_sum;
        carry_q               <= add_co;
        if (last) begin
          c_out_q <= add_co;
          ovf_q   <= (a_slice[15] == b_slice[15]) && (add_sum[15] != a_slice[15]);
          done_q  <= 1'b1;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule
